// File: rtl/router_3of6_pkg.sv
// Shared constants, FSM state type and 3-of-6 symbol helpers for the router
// transmit path.
package router_3of6_pkg;

  localparam int unsigned SYM_W     = 6;
  localparam int unsigned NUM_SYM   = 8;
  localparam int unsigned WORD_W    = NUM_SYM * SYM_W;
  localparam int unsigned PAYLOAD_W = 24;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_t;

  function automatic logic is_3of6(input logic [SYM_W-1:0] sym);
    return ($countones(sym) == 3);
  endfunction

endpackage

// File: rtl/weight_check_3of6.sv
// Combinational per-symbol weight check: bit k is set when symbol k of the
// word does not carry exactly three ones.
module weight_check_3of6 #(
  parameter int unsigned NUM_SYM = 8,
  parameter int unsigned SYM_W   = 6
) (
  input  logic [NUM_SYM*SYM_W-1:0] i_word,
  output logic [NUM_SYM-1:0]       o_err_vec
);

  import router_3of6_pkg::*;

  for (genvar k = 0; k < NUM_SYM; k++) begin : g_sym
    assign o_err_vec[k] = !is_3of6(i_word[k*SYM_W +: SYM_W]);
  end

endmodule

// File: rtl/tx_3of6_serializer.sv
// Serialises 48-bit 3-of-6 encoded words into eight 6-bit link symbols,
// MS symbol first, with one-word pending buffer and weight-error reporting.
module tx_3of6_serializer #(
  parameter int unsigned NUM_SYM   = 8,
  parameter int unsigned SYM_W     = 6,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_SYM*SYM_W-1:0] in_word,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [SYM_W-1:0]         sym_out,
  output logic                     sym_valid,
  input  logic                     sym_ready,
  output logic                     sym_first,
  output logic                     sym_last,
  output logic                     enc_err,
  output logic [ERR_CNT_W-1:0]     err_count
);

  import router_3of6_pkg::*;

  localparam int unsigned WORD_BITS = NUM_SYM * SYM_W;
  localparam int unsigned CNT_W     = (NUM_SYM > 1) ? $clog2(NUM_SYM) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(NUM_SYM - 1);

  tx_state_t              r_state, w_state_nxt;
  logic [WORD_BITS-1:0]   r_sr, w_sr_nxt;
  logic [WORD_BITS-1:0]   r_pr, w_pr_nxt;
  logic                   r_pr_full, w_pr_full_nxt;
  logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
  logic                   r_valid, w_valid_nxt;
  logic                   r_first, w_first_nxt;
  logic                   r_last, w_last_nxt;
  logic                   r_enc_err;
  logic [ERR_CNT_W-1:0]   r_err_cnt;

  logic                   w_in_xfer;
  logic                   w_beat;
  logic                   w_bypass;
  logic                   w_word_err;
  logic [NUM_SYM-1:0]     w_err_vec;

  weight_check_3of6 #(
    .NUM_SYM (NUM_SYM),
    .SYM_W   (SYM_W)
  ) u_wchk (
    .i_word    (in_word),
    .o_err_vec (w_err_vec)
  );

  assign in_ready   = !r_pr_full;
  assign w_in_xfer  = in_valid && !r_pr_full;
  assign w_beat     = r_valid && sym_ready;
  assign w_word_err = |w_err_vec;
  // Last beat with nothing pending: a new word goes straight into SR.
  assign w_bypass   = (r_state == SEND) && w_beat && (r_cnt == '0) && !r_pr_full;

  always_comb begin
    w_state_nxt   = r_state;
    w_sr_nxt      = r_sr;
    w_pr_nxt      = r_pr;
    w_pr_full_nxt = r_pr_full;
    w_cnt_nxt     = r_cnt;
    w_valid_nxt   = r_valid;
    w_first_nxt   = r_first;
    w_last_nxt    = r_last;

    unique case (r_state)
      IDLE: begin
        w_valid_nxt = 1'b0;
        w_first_nxt = 1'b0;
        w_last_nxt  = 1'b0;
        if (w_in_xfer) begin
          w_sr_nxt    = in_word;
          w_cnt_nxt   = CNT_LOAD;
          w_valid_nxt = 1'b1;
          w_first_nxt = 1'b1;
          w_state_nxt = SEND;
        end
      end

      SEND: begin
        if (w_beat) begin
          if (r_cnt != '0) begin
            w_sr_nxt    = r_sr << SYM_W;
            w_cnt_nxt   = r_cnt - CNT_W'(1);
            w_first_nxt = 1'b0;
            w_last_nxt  = (r_cnt == CNT_W'(1));
          end else if (r_pr_full) begin
            w_sr_nxt      = r_pr;
            w_pr_full_nxt = 1'b0;
            w_cnt_nxt     = CNT_LOAD;
            w_first_nxt   = 1'b1;
            w_last_nxt    = 1'b0;
          end else if (w_in_xfer) begin
            w_sr_nxt    = in_word;
            w_cnt_nxt   = CNT_LOAD;
            w_first_nxt = 1'b1;
            w_last_nxt  = 1'b0;
          end else begin
            w_valid_nxt = 1'b0;
            w_first_nxt = 1'b0;
            w_last_nxt  = 1'b0;
            w_state_nxt = IDLE;
          end
        end

        if (w_in_xfer && !w_bypass) begin
          w_pr_nxt      = in_word;
          w_pr_full_nxt = 1'b1;
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_valid_nxt = 1'b0;
        w_first_nxt = 1'b0;
        w_last_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_sr      <= '0;
      r_pr      <= '0;
      r_pr_full <= 1'b0;
      r_cnt     <= '0;
      r_valid   <= 1'b0;
      r_first   <= 1'b0;
      r_last    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_sr      <= w_sr_nxt;
      r_pr      <= w_pr_nxt;
      r_pr_full <= w_pr_full_nxt;
      r_cnt     <= w_cnt_nxt;
      r_valid   <= w_valid_nxt;
      r_first   <= w_first_nxt;
      r_last    <= w_last_nxt;
    end
  end

  // Errored words are still forwarded; only the flag and counter react.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_enc_err <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_enc_err <= w_in_xfer && w_word_err;
      if (w_in_xfer && w_word_err && (r_err_cnt != '1)) begin
        r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
      end
    end
  end

  assign sym_out   = r_sr[WORD_BITS-1 -: SYM_W];
  assign sym_valid = r_valid;
  assign sym_first = r_first;
  assign sym_last  = r_last;
  assign enc_err   = r_enc_err;
  assign err_count = r_err_cnt;

endmodule
